// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer.
// One full-adder slice per clock, LSB first, carry recirculated in a flop.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic full_adder_co(
    input logic a,
    input logic b,
    input logic ci
  );
    return (a & b) | (b & ci) | (a & ci);
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [WIDTH-1:0] racc_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic             slice_a;
  logic             slice_b;
  logic             slice_ci;
  logic             s_d;
  logic             co_d;
  logic [WIDTH-1:0] racc_d;
  logic             last_d;

  // Single bit slice: sum bit enters the accumulator MSB.
  always_comb begin
    slice_a  = ra_q[0];
    slice_b  = rb_q[0];
    slice_ci = c_q;
    s_d      = slice_a ^ slice_b ^ slice_ci;
    co_d     = full_adder_co(slice_a, slice_b, slice_ci);
    racc_d   = (racc_q >> 1) | (WIDTH'(s_d) << (WIDTH - 1));
    last_d   = (cnt_q == CW'(WIDTH - 1));
  end

  // Sequencer FSM with registered outputs; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      racc_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            ra_q    <= op_a;
            rb_q    <= op_b;
            c_q     <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          ra_q   <= ra_q >> 1;
          rb_q   <= rb_q >> 1;
          racc_q <= racc_d;
          c_q    <= co_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_d) begin
            sum_q   <= racc_d;
            cout_q  <= co_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// tb_serial_add_seq: directed and random checks of serial_add_seq
// at WIDTH=8, 13 and 1.
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] a_in [3];
  logic [31:0] b_in [3];
  logic        c_in [3];
  logic        st_in [3];

  logic        busy0, done0, cout0;
  logic [7:0]  sum0;
  logic        busy1, done1, cout1;
  logic [12:0] sum1;
  logic        busy2, done2, cout2;
  logic [0:0]  sum2;

  int n_vec = 0;
  int n_err = 0;

  serial_add_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(st_in[0]),
    .op_a(a_in[0][7:0]), .op_b(b_in[0][7:0]), .cin(c_in[0]),
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0)
  );

  serial_add_seq #(.WIDTH(13)) u_w13 (
    .clk(clk), .rst(rst), .start(st_in[1]),
    .op_a(a_in[1][12:0]), .op_b(b_in[1][12:0]), .cin(c_in[1]),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  serial_add_seq #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .start(st_in[2]),
    .op_a(a_in[2][0:0]), .op_b(b_in[2][0:0]), .cin(c_in[2]),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wd(input int k);
    return (k == 0) ? 8 : (k == 1) ? 13 : 1;
  endfunction

  function automatic logic r_busy(input int k);
    return (k == 0) ? busy0 : (k == 1) ? busy1 : busy2;
  endfunction

  function automatic logic r_done(input int k);
    return (k == 0) ? done0 : (k == 1) ? done1 : done2;
  endfunction

  function automatic longint r_res(input int k);
    longint r;
    if (k == 0) r = {55'd0, cout0, sum0};
    else if (k == 1) r = {50'd0, cout1, sum1};
    else r = {62'd0, cout2, sum2};
    return r;
  endfunction

  // Issue one add from idle, check latency, result and busy fall.
  task automatic do_add(input int k, input longint a, input longint b,
                        input logic ci);
    longint ex;
    int n;
    ex = (a + b + longint'(ci)) & ((64'sd1 <<< (wd(k) + 1)) - 1);
    a_in[k] = a[31:0];
    b_in[k] = b[31:0];
    c_in[k] = ci;
    st_in[k] = 1'b1;
    tick();
    st_in[k] = 1'b0;
    check("busy_rise", longint'(r_busy(k)), 1);
    n = 0;
    while (!r_done(k) && n < 40) begin
      tick();
      n++;
    end
    check("latency", n, wd(k));
    check("result", r_res(k), ex);
    tick();
    check("busy_done_fall", {r_busy(k), r_done(k)}, 0);
  endtask

  initial begin
    int nd, d1, d2, dprev;
    longint ra, rb;
    for (int k = 0; k < 3; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
      c_in[k] = 1'b0;
      st_in[k] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      check("reset_state", {r_busy(k), r_done(k), r_res(k)}, 0);

    // Basic add
    do_add(0, 'h5A, 'h3C, 1'b0);

    // Full carry ripple, results must hold while idle
    do_add(0, 'hFF, 'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_100", r_res(0), 'h100);
    end
    do_add(0, 'hFF, 'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_1ff", r_res(0), 'h1FF);
    end

    // Start while busy: pulses in SHIFT (E3, E8) and DONE (E9) ignored
    nd = 0; d1 = -1; d2 = -1;
    for (int e = 0; e <= 22; e++) begin
      st_in[0] = (e == 0 || e == 3 || e == 8 || e == 9 || e == 10);
      a_in[0] = (e == 0) ? 32'h10 : 32'hAA;
      b_in[0] = (e == 0) ? 32'h20 : 32'h55;
      c_in[0] = 1'b0;
      tick();
      if (done0) begin
        nd++;
        if (nd == 1) begin
          d1 = e;
          check("sbusy_first", r_res(0), 'h030);
        end else begin
          d2 = e;
          check("sbusy_second", r_res(0), 'h0FF);
        end
      end
    end
    st_in[0] = 1'b0;
    check("sbusy_ndone", nd, 2);
    check("sbusy_d1", d1, 8);
    check("sbusy_d2", d2, 18);

    // Reset mid-operation
    nd = 0;
    for (int e = 0; e <= 16; e++) begin
      st_in[0] = (e == 0);
      a_in[0] = 32'h7F;
      b_in[0] = 32'h01;
      rst = (e == 4);
      tick();
      if (e == 4)
        check("rst_outputs", {busy0, done0, r_res(0)}, 0);
      if (e >= 4 && done0) nd++;
    end
    rst = 1'b0;
    st_in[0] = 1'b0;
    check("rst_no_done", nd, 0);
    do_add(0, 'h03, 'h04, 1'b0);

    // WIDTH=1
    do_add(2, 1, 1, 1'b1);
    nd = 0; dprev = -1;
    st_in[2] = 1'b1;
    a_in[2] = 32'h1;
    b_in[2] = 32'h0;
    c_in[2] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done2) begin
        nd++;
        check("w1_result", r_res(2), 'h1);
        if (dprev >= 0) check("w1_period", e - dprev, 3);
        dprev = e;
      end
    end
    st_in[2] = 1'b0;
    check("w1_ndone", nd, 4);
    tick();
    tick();

    // Random regression
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 500; i++) begin
        ra = longint'($urandom) & ((64'sd1 <<< wd(k)) - 1);
        rb = longint'($urandom) & ((64'sd1 <<< wd(k)) - 1);
        repeat ($urandom_range(0, 3)) tick();
        do_add(k, ra, rb, 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
